// File: rtl/term_rst_sequencer.sv
// Reset sequencer: staged system/CPU reset release, then run
// until every core terminates or the watchdog expires.
module term_rst_sequencer #(
   parameter int NUM_CORES      = 4,
   parameter int SYS_HOLD       = 16,
   parameter int CPU_HOLD       = 8,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CORES-1:0] term_i,
   input  logic                 sw_rst_req_i,
   output logic                 rst_sys_o,
   output logic                 rst_cpu_o,
   output logic                 running_o,
   output logic                 all_done_o,
   output logic                 timeout_o,
   output logic [NUM_CORES-1:0] done_mask_o,
   output logic [31:0]          cycle_cnt_o
);

   localparam logic [2:0] S_RST_SYS = 3'd0;
   localparam logic [2:0] S_RST_CPU = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_DONE    = 3'd3;
   localparam logic [2:0] S_TIMEOUT = 3'd4;

   localparam logic [7:0]  SYS_LAST = 8'(SYS_HOLD - 1);
   localparam logic [7:0]  CPU_LAST = 8'(CPU_HOLD - 1);
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);

   localparam logic [NUM_CORES-1:0] ALL_ONES = '1;

   logic [2:0]           r_state;
   logic [7:0]           r_hold;
   logic [31:0]          r_cnt;
   logic [NUM_CORES-1:0] r_mask;
   logic                 r_rst_sys;
   logic                 r_rst_cpu;
   logic                 r_running;
   logic                 r_all_done;
   logic                 r_timeout;

   logic [2:0]           w_nxt;
   logic [7:0]           w_hold_nxt;
   logic [31:0]          w_cnt_nxt;
   logic [NUM_CORES-1:0] w_mask_nxt;
   logic [NUM_CORES-1:0] w_mask_or;

   // Next-state, hold counter, cycle counter and mask update
   always_comb begin
      w_mask_or  = r_mask | term_i;
      w_nxt      = r_state;
      w_hold_nxt = 8'd0;
      w_cnt_nxt  = r_cnt;
      w_mask_nxt = r_mask;
      if (sw_rst_req_i) begin
         w_nxt      = S_RST_SYS;
         w_cnt_nxt  = 32'd0;
         w_mask_nxt = '0;
      end else begin
         unique case (r_state)
            S_RST_SYS: begin
               if (r_hold == SYS_LAST) w_nxt = S_RST_CPU;
               else w_hold_nxt = r_hold + 8'd1;
            end
            S_RST_CPU: begin
               if (r_hold == CPU_LAST) w_nxt = S_RUN;
               else w_hold_nxt = r_hold + 8'd1;
            end
            S_RUN: begin
               w_mask_nxt = w_mask_or;
               if (w_mask_or == ALL_ONES) begin
                  w_nxt = S_DONE;
               end else if (WD_EN && (r_cnt == TO_LAST)) begin
                  w_nxt = S_TIMEOUT;
               end else if (r_cnt != 32'hFFFF_FFFF) begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end
            S_DONE, S_TIMEOUT: w_nxt = r_state;
            default: begin
               w_nxt      = S_RST_SYS;
               w_cnt_nxt  = 32'd0;
               w_mask_nxt = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs decoded from next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_RST_SYS;
         r_hold     <= 8'd0;
         r_cnt      <= 32'd0;
         r_mask     <= '0;
         r_rst_sys  <= 1'b1;
         r_rst_cpu  <= 1'b1;
         r_running  <= 1'b0;
         r_all_done <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_hold     <= w_hold_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mask     <= w_mask_nxt;
         r_rst_sys  <= (w_nxt == S_RST_SYS);
         r_rst_cpu  <= (w_nxt == S_RST_SYS) || (w_nxt == S_RST_CPU);
         r_running  <= (w_nxt == S_RUN);
         r_all_done <= (w_nxt == S_DONE);
         r_timeout  <= (w_nxt == S_TIMEOUT);
      end
   end

   assign rst_sys_o   = r_rst_sys;
   assign rst_cpu_o   = r_rst_cpu;
   assign running_o   = r_running;
   assign all_done_o  = r_all_done;
   assign timeout_o   = r_timeout;
   assign done_mask_o = r_mask;
   assign cycle_cnt_o = r_cnt;

endmodule

// File: tb/tb_term_rst_sequencer.sv
// Bench: two sequencers (watchdog 100 / watchdog off) driven in
// lockstep and compared every cycle with an age-based model.
module tb_term_rst_sequencer;

   localparam int SH = 16;
   localparam int CH = 8;

   logic       clk;
   logic       rst_n;
   logic [3:0] term;
   logic       sw;

   logic        sys1, cpu1, run1, done1, to1;
   logic [3:0]  mask1;
   logic [31:0] cnt1;
   logic        sys0, cpu0, run0, done0, to0;
   logic [3:0]  mask0;
   logic [31:0] cnt0;

   int errs;
   int checks;

   term_rst_sequencer #(
      .NUM_CORES(4), .SYS_HOLD(SH), .CPU_HOLD(CH), .TIMEOUT_CYCLES(100)
   ) u_wd (
      .clk(clk), .rst_n(rst_n), .term_i(term), .sw_rst_req_i(sw),
      .rst_sys_o(sys1), .rst_cpu_o(cpu1), .running_o(run1),
      .all_done_o(done1), .timeout_o(to1),
      .done_mask_o(mask1), .cycle_cnt_o(cnt1)
   );

   term_rst_sequencer u_nowd (
      .clk(clk), .rst_n(rst_n), .term_i(term), .sw_rst_req_i(sw),
      .rst_sys_o(sys0), .rst_cpu_o(cpu0), .running_o(run0),
      .all_done_o(done0), .timeout_o(to0),
      .done_mask_o(mask0), .cycle_cnt_o(cnt0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: "age" = cycles spent since the reset sequence
   // restarted, capped once RUN is reached.
   int          tov [2] = '{0, 100};
   int          age [2];
   bit          mdone [2];
   bit          mto [2];
   logic [3:0]  mmask [2];
   logic [31:0] mcnt [2];
   logic [3:0]  nm;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n || sw) begin
            age[k] = 0; mdone[k] = 0; mto[k] = 0;
            mmask[k] = 4'h0; mcnt[k] = 32'd0;
         end else if (age[k] < SH + CH) begin
            age[k] = age[k] + 1;
         end else if (!mdone[k] && !mto[k]) begin
            nm = mmask[k] | term;
            mmask[k] = nm;
            if (nm == 4'hF) mdone[k] = 1;
            else if (tov[k] != 0 && mcnt[k] == 32'(tov[k] - 1)) mto[k] = 1;
            else if (mcnt[k] != 32'hFFFF_FFFF) mcnt[k] = mcnt[k] + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp(input int k, input logic s, input logic c,
                      input logic r, input logic d, input logic t,
                      input logic [3:0] m, input logic [31:0] n);
      bit in_run;
      in_run = (age[k] >= SH + CH);
      chk($sformatf("u%0d_rst_sys", k), 32'(s), 32'(age[k] < SH));
      chk($sformatf("u%0d_rst_cpu", k), 32'(c), 32'(age[k] < SH + CH));
      chk($sformatf("u%0d_running", k), 32'(r),
          32'(in_run && !mdone[k] && !mto[k]));
      chk($sformatf("u%0d_all_done", k), 32'(d), 32'(mdone[k]));
      chk($sformatf("u%0d_timeout", k), 32'(t), 32'(mto[k]));
      chk($sformatf("u%0d_mask", k), 32'(m), 32'(mmask[k]));
      chk($sformatf("u%0d_cnt", k), n, mcnt[k]);
   endtask

   task automatic cyc(input logic [3:0] t, input logic s, input logic r);
      term = t; sw = s; rst_n = r;
      @(posedge clk);
      #1;
      cmp(0, sys0, cpu0, run0, done0, to0, mask0, cnt0);
      cmp(1, sys1, cpu1, run1, done1, to1, mask1, cnt1);
   endtask

   task automatic idle(input int n, input logic [3:0] t);
      for (int i = 0; i < n; i++) cyc(t, 1'b0, 1'b1);
   endtask

   initial begin
      int n;
      int rel;
      errs = 0; checks = 0;
      term = 4'h0; sw = 1'b0; rst_n = 1'b0;

      // power-on reset, 3 cycles low
      for (int i = 0; i < 3; i++) cyc(4'h0, 1'b0, 1'b0);
      chk("reset_sys", 32'(sys1), 32'd1);
      chk("reset_cnt", cnt1, 32'd0);

      // release: rst_sys falls on the 16th high edge, rst_cpu 8 later
      rel = 0;
      while (sys1 && rel < 40) begin cyc(4'h0, 1'b0, 1'b1); rel++; end
      chk("sys_hold_len", 32'(rel), 32'(SH));
      rel = 0;
      while (cpu1 && rel < 40) begin cyc(4'h0, 1'b0, 1'b1); rel++; end
      chk("cpu_hold_len", 32'(rel), 32'(CH));
      chk("run_at_cpu_fall", 32'(run1), 32'd1);

      // staged termination 1, 5, F
      idle(3, 4'h0);
      cyc(4'h1, 1'b0, 1'b1);
      chk("mask_step1", 32'(mask1), 32'h1);
      idle(2, 4'h0);
      cyc(4'h4, 1'b0, 1'b1);
      chk("mask_step5", 32'(mask1), 32'h5);
      idle(2, 4'h0);
      cyc(4'hA, 1'b0, 1'b1);
      chk("mask_stepF", 32'(mask1), 32'hF);
      chk("done_rise", 32'(done1), 32'd1);
      idle(5, 4'h3);

      // soft reset out of DONE, full sequence repeats
      cyc(4'h0, 1'b1, 1'b1);
      chk("sw_sys", 32'(sys1), 32'd1);
      chk("sw_mask", 32'(mask1), 32'h0);
      idle(SH + CH + 2, 4'h0);

      // watchdog expiry on the 100th RUN cycle
      idle(110, 4'h0);
      chk("to_flag", 32'(to1), 32'd1);
      chk("to_cnt", cnt1, 32'd99);
      chk("nowd_running", 32'(run0), 32'd1);

      // mask completes on the watchdog cycle: DONE wins
      cyc(4'h0, 1'b1, 1'b1);
      n = 0;
      while (!(run1 && cnt1 == 32'd99) && n < 300) begin
         idle(1, 4'h0); n++;
      end
      chk("reach_cnt99", 32'(n < 300), 32'd1);
      cyc(4'hF, 1'b0, 1'b1);
      chk("race_done", 32'(done1), 32'd1);
      chk("race_to", 32'(to1), 32'd0);
      idle(3, 4'h0);

      // rst_n during RST_CPU with term held high
      cyc(4'hF, 1'b1, 1'b1);
      idle(SH + 2, 4'hF);
      cyc(4'hF, 1'b0, 1'b0);
      chk("rstcpu_mask", 32'(mask1), 32'h0);
      idle(SH + CH - 1, 4'hF);
      chk("term_ignored", 32'(mask1), 32'h0);
      idle(3, 4'hF);

      // rst_n during RUN
      cyc(4'h0, 1'b1, 1'b1);
      idle(SH + CH + 10, 4'h2);
      cyc(4'h0, 1'b0, 1'b0);
      chk("rstrun_sys", 32'(sys1), 32'd1);
      idle(SH + CH + 4, 4'h0);

      // soft reset simultaneous with DONE entry
      cyc(4'hF, 1'b1, 1'b1);
      chk("sw_prio_done", 32'(done1), 32'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic [3:0] t;
         logic s;
         logic r;
         t = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
         s = ($urandom_range(0, 249) == 0);
         r = !($urandom_range(0, 399) == 0);
         cyc(t, s, r);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
